dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Data-memory slave that sits at the far end of the MEM-stage load/store interface.
//   Accepts word/half/byte requests (re/we, 4-bit byte select, address, write data).
//   Reports progress on the 2-bit busy/done handshake that the MEM stage stalls on.
//   Backed by an internal word array with programmable wait states; used for simulation
//   and as the synthesizable on-chip DMEM.
// PARAMETERS
//   DEPTH_WORDS  1024  number of 32-bit words in the array (power of 2)
//   BASE_ADDR    32'h0 byte address of word 0; requests outside [BASE, BASE+4*DEPTH) are out-of-range
//   WAIT_CYCLES  1     extra access cycles, 0..15
// PORTS
//   clk        in   1   clock, all state updates on rising edge
//   rst        in   1   reset, synchronous, active-high
//   mem_re     in   1   read request
//   mem_we     in   1   write request
//   mem_sel    in   4   byte-lane enables for writes; sel[i] -> wdata[8i+7:8i]
//   mem_addr   in   32  byte address; bits [1:0] ignored for array indexing
//   mem_wdata  in   32  write data, already lane-replicated by requester
//   mem_rdata  out  32  full aligned read word; requester extracts byte/half
//   mem_busy   out  2   [0] read in progress, [1] write in progress
//   mem_done   out  2   [0] read data valid pulse, [1] write committed pulse
//   mem_err    out  1   one-cycle pulse with done: request was out-of-range
// BEHAVIOUR
//   Reset: state=IDLE, mem_busy=0, mem_done=0, mem_err=0, mem_rdata=0, counter=0.
//     Array contents are not cleared.
//   FSM states: IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE: if (mem_re|mem_we) at an edge, capture addr, wdata, sel and type; load cnt=WAIT_CYCLES;
//     go ACCESS.
//     - re&we both high: treat as write; read ignored.
//     - Neither high: stay IDLE.
//   ACCESS: mem_busy[0]=type==read, mem_busy[1]=type==write. All inputs ignored.
//     - cnt!=0: decrement.
//     - cnt==0: perform the array access at that edge, then go DONE.
//       Read: mem_rdata <= array[idx]. Write: each lane with sel[i]=1 is updated.
//     - ACCESS lasts WAIT_CYCLES+1 cycles.
//   DONE: one cycle. mem_busy=0; mem_done[0] or [1]=1 per type; mem_err=1 if out-of-range.
//     Always return to IDLE; requests seen in DONE are ignored.
//   Latency: request sampled at edge T; busy high T+1..T+WAIT_CYCLES+1; done high at T+WAIT_CYCLES+2.
//   idx = (addr-BASE_ADDR)>>2, using log2(DEPTH_WORDS) bits.
//   mem_rdata holds its value until the next read completes; writes do not alter it.
//   Out-of-range: write dropped (array untouched); read returns mem_rdata=0; mem_err pulses in DONE.
//   Write with sel=4'b0000: full handshake, no array change, no error.
//   Requester must drop re/we after seeing done. A request still held in IDLE is accepted again
//     as a new access.
//   Reset mid-ACCESS: transaction aborted, pending write not committed, no done pulse.
//   Back-to-back accesses: minimum spacing is WAIT_CYCLES+3 cycles between accepted requests.
// TESTING
//   1. WAIT_CYCLES=1: write 32'hDEADBEEF @0x10, sel=1111.
//      -> busy[1]=1 for 2 cycles, done[1] one cycle.
//      Then read @0x10 -> done[0] at T+3, rdata=DEADBEEF.
//   2. Byte lane: with 0x10=DEADBEEF, write wdata=32'h55555555 sel=0100 @0x12.
//      -> read @0x10 returns DE55BEEF.
//   3. re=we=1 @0x20 wdata=1234_5678 -> treated as write: busy=2'b10, done=2'b10.
//      rdata unchanged; subsequent read returns 12345678.
//   4. Out-of-range read @BASE+4*DEPTH -> done[0]=1, mem_err=1, rdata=0.
//      Out-of-range write -> mem_err=1, array unchanged.
//   5. WAIT_CYCLES=3: rst asserted during 2nd ACCESS cycle of a write.
//      -> busy=0, done never pulses; readback shows old data.
//   6. WAIT_CYCLES=0: re held high continuously @0x10.
//      -> done[0] every 3rd cycle (busy,done,idle pattern); rdata stable.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Load/store bus between the MEM-stage requester and the data-memory responder.
// The requester drives the request fields and watches the busy/done/err handshake.
interface dmem_responder_if;
    logic        mem_re;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_busy;
    logic [1:0]  mem_done;
    logic        mem_err;

    modport master (
        output mem_re, mem_we, mem_sel, mem_addr, mem_wdata,
        input  mem_rdata, mem_busy, mem_done, mem_err
    );

    modport slave (
        input  mem_re, mem_we, mem_sel, mem_addr, mem_wdata,
        output mem_rdata, mem_busy, mem_done, mem_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory slave: word array with programmable wait states behind the MEM-stage
// busy/done handshake. IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE (one cycle) -> IDLE.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);
    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t             state_r, state_next_s;
    logic [3:0]         cnt_r, cnt_next_s;
    logic               is_write_r;
    logic               in_range_r;
    logic [IDX_W-1:0]   idx_r;
    logic [31:0]        wdata_r;
    logic [3:0]         sel_r;
    logic [31:0]        rdata_r;
    logic [1:0]         busy_r, busy_next_s;
    logic [1:0]         done_r, done_next_s;
    logic               err_r, err_next_s;
    logic               capture_s;
    logic               access_s;
    logic               mem_wr_s;
    logic [32:0]        offset_s;
    logic               req_in_range_s;
    logic [31:0]        mem_r [DEPTH_WORDS];

    // 33-bit subtraction: an address below BASE_ADDR borrows into bit 32 and lands out of range
    assign offset_s       = {1'b0, bus.mem_addr} - {1'b0, BASE_ADDR};
    assign req_in_range_s = (offset_s < SPAN);

    // Reset blocks the array write so an aborted access never commits
    assign mem_wr_s = access_s && is_write_r && in_range_r && !rst;

    assign bus.mem_rdata = rdata_r;
    assign bus.mem_busy  = busy_r;
    assign bus.mem_done  = done_r;
    assign bus.mem_err   = err_r;

    // Next-state and next-output decode
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        busy_next_s  = busy_r;
        done_next_s  = 2'b00;
        err_next_s   = 1'b0;
        capture_s    = 1'b0;
        access_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.mem_re || bus.mem_we) begin
                    capture_s    = 1'b1;
                    cnt_next_s   = WAIT_LOAD;
                    busy_next_s  = bus.mem_we ? 2'b10 : 2'b01;
                    state_next_s = ST_ACCESS;
                end else begin
                    busy_next_s  = 2'b00;
                end
            end
            ST_ACCESS: begin
                if (cnt_r != 4'd0) begin
                    cnt_next_s   = cnt_r - 4'd1;
                end else begin
                    access_s     = 1'b1;
                    busy_next_s  = 2'b00;
                    done_next_s  = is_write_r ? 2'b10 : 2'b01;
                    err_next_s   = !in_range_r;
                    state_next_s = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_next_s  = 2'b00;
                state_next_s = ST_IDLE;
            end
            default: begin
                busy_next_s  = 2'b00;
                cnt_next_s   = 4'd0;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, captured request and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            is_write_r <= 1'b0;
            in_range_r <= 1'b0;
            idx_r      <= '0;
            wdata_r    <= 32'h0000_0000;
            sel_r      <= 4'b0000;
            rdata_r    <= 32'h0000_0000;
            busy_r     <= 2'b00;
            done_r     <= 2'b00;
            err_r      <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
            err_r   <= err_next_s;
            if (capture_s) begin
                is_write_r <= bus.mem_we;
                in_range_r <= req_in_range_s;
                idx_r      <= offset_s[IDX_W+1:2];
                wdata_r    <= bus.mem_wdata;
                sel_r      <= bus.mem_sel;
            end
            if (access_s && !is_write_r) begin
                rdata_r <= in_range_r ? mem_r[idx_r] : 32'h0000_0000;
            end
        end
    end

    // Array write port, byte-lane masked; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_wr_s) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_r[i]) begin
                    mem_r[idx_r][8*i +: 8] <= wdata_r[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (WAIT_CYCLES 1, 3, 0) driven by
// directed scenarios and a randomized load/store mix checked against a word-array model.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst1 = 1'b1;
    logic rst3 = 1'b1;
    logic rst0 = 1'b1;

    always #5 clk = ~clk;

    dmem_responder_if bus1 ();
    dmem_responder_if bus3 ();
    dmem_responder_if bus0 ();

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst1), .bus(bus1.slave));
    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst3), .bus(bus3.slave));
    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst0), .bus(bus0.slave));

    int checks = 0;
    int errors = 0;

    // Reference model of words 0..15 of the WAIT_CYCLES=1 instance and its read register
    logic [31:0] ref_mem [16];
    logic [31:0] ref_rd;

    task automatic set_req(input int inst, input logic re, input logic we, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] wdata);
        case (inst)
            1: begin
                bus1.mem_re = re; bus1.mem_we = we; bus1.mem_sel = sel;
                bus1.mem_addr = addr; bus1.mem_wdata = wdata;
            end
            3: begin
                bus3.mem_re = re; bus3.mem_we = we; bus3.mem_sel = sel;
                bus3.mem_addr = addr; bus3.mem_wdata = wdata;
            end
            default: begin
                bus0.mem_re = re; bus0.mem_we = we; bus0.mem_sel = sel;
                bus0.mem_addr = addr; bus0.mem_wdata = wdata;
            end
        endcase
    endtask

    task automatic get_out(input int inst, output logic [1:0] b, output logic [1:0] d,
                           output logic e, output logic [31:0] r);
        case (inst)
            1:       begin b = bus1.mem_busy; d = bus1.mem_done; e = bus1.mem_err; r = bus1.mem_rdata; end
            3:       begin b = bus3.mem_busy; d = bus3.mem_done; e = bus3.mem_err; r = bus3.mem_rdata; end
            default: begin b = bus0.mem_busy; d = bus0.mem_done; e = bus0.mem_err; r = bus0.mem_rdata; end
        endcase
    endtask

    // One request: present at a negedge, hold until done is seen (bounded), then release.
    // done_at counts sampling points after the accepting edge (0 = never seen).
    task automatic txn(input int inst, input logic re, input logic we, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int n_busy, output logic busy_ok, output int done_at,
                       output logic [1:0] done_v, output logic err_v, output logic [31:0] rd_v,
                       output logic pulse_ok);
        logic [1:0]  b, d, exp_b;
        logic        e;
        logic [31:0] r;
        exp_b   = we ? 2'b10 : 2'b01;
        n_busy  = 0;
        busy_ok = 1'b1;
        done_at = 0;
        done_v  = 2'b00;
        err_v   = 1'b0;
        rd_v    = 32'h0;
        @(negedge clk);
        set_req(inst, re, we, sel, addr, wdata);
        @(posedge clk);
        for (int k = 1; k <= 40 && done_at == 0; k++) begin
            @(negedge clk);
            get_out(inst, b, d, e, r);
            if (b != 2'b00) begin
                n_busy++;
                if (b !== exp_b) busy_ok = 1'b0;
            end
            if (d != 2'b00) begin
                done_at = k;
                done_v  = d;
                err_v   = e;
                rd_v    = r;
            end
        end
        set_req(inst, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        @(negedge clk);
        get_out(inst, b, d, e, r);
        pulse_ok = (b === 2'b00) && (d === 2'b00) && (e === 1'b0);
    endtask

    task automatic test_reset();
        int          insts [3] = '{1, 3, 0};
        logic [1:0]  b, d;
        logic        e;
        logic [31:0] r;
        set_req(1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        set_req(3, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        set_req(0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        rst1 = 1'b0; rst3 = 1'b0; rst0 = 1'b0;
        @(negedge clk);
        foreach (insts[i]) begin
            get_out(insts[i], b, d, e, r);
            checks++;
            if ({b, d, e, r} !== 37'h0) begin
                errors++;
                $display("FAIL reset_outputs inst%0d: busy=%b done=%b err=%b rdata=%h, expected all zero",
                         insts[i], b, d, e, r);
            end
        end
    endtask

    task automatic test_preload();
        int nb, da; logic bo, po, ev; logic [1:0] dv; logic [31:0] rv;
        for (int w = 0; w < 16; w++) begin
            ref_mem[w] = $urandom;
            txn(1, 1'b0, 1'b1, 4'b1111, 32'(w * 4), ref_mem[w], nb, bo, da, dv, ev, rv, po);
            checks++;
            if (dv !== 2'b10 || ev !== 1'b0 || da != 3) begin
                errors++;
                $display("FAIL preload_write w%0d: done=%b err=%b at=%0d, expected 10/0/3", w, dv, ev, da);
            end
        end
        ref_rd = 32'h0;
    endtask

    task automatic test_basic();
        int nb, da; logic bo, po, ev; logic [1:0] dv; logic [31:0] rv;
        txn(1, 1'b0, 1'b1, 4'b1111, 32'h10, 32'hDEAD_BEEF, nb, bo, da, dv, ev, rv, po);
        ref_mem[4] = 32'hDEAD_BEEF;
        checks++;
        if (nb != 2 || bo !== 1'b1) begin
            errors++;
            $display("FAIL basic_write_busy: busy cycles=%0d ok=%b, expected 2 cycles of 10", nb, bo);
        end
        checks++;
        if (da != 3 || dv !== 2'b10 || ev !== 1'b0 || po !== 1'b1) begin
            errors++;
            $display("FAIL basic_write_done: at=%0d done=%b err=%b single=%b, expected 3/10/0/1", da, dv, ev, po);
        end
        txn(1, 1'b1, 1'b0, 4'b0000, 32'h10, 32'h0, nb, bo, da, dv, ev, rv, po);
        ref_rd = 32'hDEAD_BEEF;
        checks++;
        if (nb != 2 || bo !== 1'b1 || da != 3 || dv !== 2'b01) begin
            errors++;
            $display("FAIL basic_read_timing: busy=%0d ok=%b at=%0d done=%b, expected 2/1/3/01", nb, bo, da, dv);
        end
        checks++;
        if (rv !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL basic_read_data: got %h, expected deadbeef", rv);
        end
    endtask

    task automatic test_byte_lane();
        int nb, da; logic bo, po, ev; logic [1:0] dv; logic [31:0] rv;
        txn(1, 1'b0, 1'b1, 4'b0100, 32'h12, 32'h5555_5555, nb, bo, da, dv, ev, rv, po);
        ref_mem[4] = 32'hDE55_BEEF;
        txn(1, 1'b1, 1'b0, 4'b0000, 32'h10, 32'h0, nb, bo, da, dv, ev, rv, po);
        ref_rd = 32'hDE55_BEEF;
        checks++;
        if (rv !== 32'hDE55_BEEF) begin
            errors++;
            $display("FAIL byte_lane_merge: got %h, expected de55beef", rv);
        end
    endtask

    task automatic test_re_we_both();
        int nb, da; logic bo, po, ev; logic [1:0] dv; logic [31:0] rv;
        txn(1, 1'b1, 1'b1, 4'b1111, 32'h20, 32'h1234_5678, nb, bo, da, dv, ev, rv, po);
        ref_mem[8] = 32'h1234_5678;
        checks++;
        if (bo !== 1'b1 || nb != 2 || dv !== 2'b10) begin
            errors++;
            $display("FAIL both_as_write: busy ok=%b cycles=%0d done=%b, expected 1/2/10", bo, nb, dv);
        end
        checks++;
        if (rv !== ref_rd) begin
            errors++;
            $display("FAIL both_rdata_held: got %h, expected %h", rv, ref_rd);
        end
        txn(1, 1'b1, 1'b0, 4'b0000, 32'h20, 32'h0, nb, bo, da, dv, ev, rv, po);
        ref_rd = 32'h1234_5678;
        checks++;
        if (rv !== 32'h1234_5678) begin
            errors++;
            $display("FAIL both_readback: got %h, expected 12345678", rv);
        end
    endtask

    task automatic test_out_of_range();
        int nb, da; logic bo, po, ev; logic [1:0] dv; logic [31:0] rv;
        txn(1, 1'b1, 1'b0, 4'b0000, 32'h1000, 32'h0, nb, bo, da, dv, ev, rv, po);
        ref_rd = 32'h0;
        checks++;
        if (dv !== 2'b01 || ev !== 1'b1 || rv !== 32'h0 || da != 3) begin
            errors++;
            $display("FAIL oor_read: done=%b err=%b rdata=%h at=%0d, expected 01/1/0/3", dv, ev, rv, da);
        end
        checks++;
        if (po !== 1'b1) begin
            errors++;
            $display("FAIL oor_err_pulse: err/done still high after one cycle (%b), expected cleared", po);
        end
        // 0x1008 aliases word 2 in the index bits; the write must still be dropped
        txn(1, 1'b0, 1'b1, 4'b1111, 32'h1008, ~ref_mem[2], nb, bo, da, dv, ev, rv, po);
        checks++;
        if (dv !== 2'b10 || ev !== 1'b1) begin
            errors++;
            $display("FAIL oor_write: done=%b err=%b, expected 10/1", dv, ev);
        end
        txn(1, 1'b0, 1'b1, 4'b0000, 32'h8, ~ref_mem[2], nb, bo, da, dv, ev, rv, po);
        checks++;
        if (dv !== 2'b10 || ev !== 1'b0 || da != 3) begin
            errors++;
            $display("FAIL sel_zero_write: done=%b err=%b at=%0d, expected 10/0/3", dv, ev, da);
        end
        txn(1, 1'b1, 1'b0, 4'b0000, 32'h8, 32'h0, nb, bo, da, dv, ev, rv, po);
        ref_rd = ref_mem[2];
        checks++;
        if (rv !== ref_mem[2] || ev !== 1'b0) begin
            errors++;
            $display("FAIL oor_array_untouched: got %h err=%b, expected %h err=0", rv, ev, ref_mem[2]);
        end
    endtask

    task automatic test_random();
        int nb, da; logic bo, po, ev; logic [1:0] dv; logic [31:0] rv;
        logic re, we, in_rng;
        logic [3:0] sel;
        logic [31:0] addr, wd;
        int w;
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 2))
                0:       begin re = 1'b1; we = 1'b0; end
                1:       begin re = 1'b0; we = 1'b1; end
                default: begin re = 1'b1; we = 1'b1; end
            endcase
            if ($urandom_range(0, 7) == 0) addr = 32'h1000 + 32'($urandom_range(0, 8191));
            else                           addr = 32'($urandom_range(0, 63));
            sel    = 4'($urandom_range(0, 15));
            wd     = $urandom;
            in_rng = (addr < 32'h1000);
            w      = int'(addr[5:2]);
            txn(1, re, we, sel, addr, wd, nb, bo, da, dv, ev, rv, po);
            if (we) begin
                if (in_rng)
                    for (int l = 0; l < 4; l++)
                        if (sel[l]) ref_mem[w][8*l +: 8] = wd[8*l +: 8];
            end else begin
                ref_rd = in_rng ? ref_mem[w] : 32'h0;
            end
            checks++;
            if (dv !== (we ? 2'b10 : 2'b01) || ev !== !in_rng) begin
                errors++;
                $display("FAIL rand_done #%0d addr=%h: done=%b err=%b, expected %b/%b",
                         n, addr, dv, ev, (we ? 2'b10 : 2'b01), !in_rng);
            end
            checks++;
            if (nb != 2 || bo !== 1'b1 || da != 3 || po !== 1'b1) begin
                errors++;
                $display("FAIL rand_timing #%0d: busy=%0d ok=%b at=%0d single=%b, expected 2/1/3/1",
                         n, nb, bo, da, po);
            end
            checks++;
            if (rv !== ref_rd) begin
                errors++;
                $display("FAIL rand_rdata #%0d addr=%h: got %h, expected %h", n, addr, rv, ref_rd);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int nb, da; logic bo, po, ev; logic [1:0] dv; logic [31:0] rv;
        logic [1:0] b, d; logic e; logic [31:0] r;
        logic seen_done;
        txn(3, 1'b0, 1'b1, 4'b1111, 32'h10, 32'h1111_1111, nb, bo, da, dv, ev, rv, po);
        checks++;
        if (nb != 4 || da != 5 || dv !== 2'b10) begin
            errors++;
            $display("FAIL w3_write_timing: busy=%0d at=%0d done=%b, expected 4/5/10", nb, da, dv);
        end
        @(negedge clk);
        set_req(3, 1'b0, 1'b1, 4'b1111, 32'h10, 32'hAAAA_AAAA);
        @(posedge clk);
        @(negedge clk);
        get_out(3, b, d, e, r);
        checks++;
        if (b !== 2'b10) begin
            errors++;
            $display("FAIL w3_busy_before_reset: busy=%b, expected 10", b);
        end
        @(negedge clk);
        rst3 = 1'b1;
        set_req(3, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
        @(negedge clk);
        rst3 = 1'b0;
        get_out(3, b, d, e, r);
        checks++;
        if (b !== 2'b00 || d !== 2'b00) begin
            errors++;
            $display("FAIL w3_reset_abort: busy=%b done=%b, expected 00/00", b, d);
        end
        seen_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            get_out(3, b, d, e, r);
            if (d != 2'b00) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            errors++;
            $display("FAIL w3_no_done_after_abort: done pulse seen=%b, expected 0", seen_done);
        end
        txn(3, 1'b1, 1'b0, 4'b0000, 32'h10, 32'h0, nb, bo, da, dv, ev, rv, po);
        checks++;
        if (rv !== 32'h1111_1111 || da != 5) begin
            errors++;
            $display("FAIL w3_old_data_kept: got %h at=%0d, expected 11111111 at 5", rv, da);
        end
    endtask

    task automatic test_continuous_read();
        int nb, da; logic bo, po, ev; logic [1:0] dv; logic [31:0] rv;
        logic [1:0] b, d, exp_b, exp_d; logic e; logic [31:0] r;
        txn(0, 1'b0, 1'b1, 4'b1111, 32'h10, 32'hCAFE_F00D, nb, bo, da, dv, ev, rv, po);
        checks++;
        if (nb != 1 || da != 2 || dv !== 2'b10) begin
            errors++;
            $display("FAIL w0_write_timing: busy=%0d at=%0d done=%b, expected 1/2/10", nb, da, dv);
        end
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 4'b0000, 32'h10, 32'h0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            get_out(0, b, d, e, r);
            exp_b = (k % 3 == 1) ? 2'b01 : 2'b00;
            exp_d = (k % 3 == 2) ? 2'b01 : 2'b00;
            checks++;
            if (b !== exp_b || d !== exp_d) begin
                errors++;
                $display("FAIL w0_held_pattern k=%0d: busy=%b done=%b, expected %b/%b", k, b, d, exp_b, exp_d);
            end
            if (k >= 2) begin
                checks++;
                if (r !== 32'hCAFE_F00D) begin
                    errors++;
                    $display("FAIL w0_held_rdata k=%0d: got %h, expected cafef00d", k, r);
                end
            end
        end
        set_req(0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_preload();
        test_basic();
        test_byte_lane();
        test_re_we_both();
        test_out_of_range();
        test_random();
        test_reset_mid_access();
        test_continuous_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
